// File: rtl/restador_8bits.sv
// Registered subtractor / down-counter slice with borrow chaining.
// Q, BO and ZERO update on rising CLK; borrow out cascades into the next slice's BI or ENB.
module restador_8bits #(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             BI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             ZERO
);

  localparam int unsigned DW = WIDTH + 1;

  localparam logic [1:0] MODO_SUB  = 2'b00;
  localparam logic [1:0] MODO_DEC  = 2'b01;
  localparam logic [1:0] MODO_ACC  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             bo_q, bo_d;
  logic             zero_q, zero_d;
  logic [DW-1:0]    diff;
  logic             clamp;

  // Next-state: one-cycle arithmetic on the selected operands
  always_comb begin
    q_d    = q_q;
    bo_d   = bo_q;
    zero_d = zero_q;
    diff   = '0;
    clamp  = 1'b0;
    if (ENB) begin
      case (MODO)
        MODO_SUB: begin
          diff  = DW'(A) - DW'(B) - DW'(BI);
          q_d   = diff[WIDTH-1:0];
          bo_d  = diff[WIDTH];
          clamp = SAT & diff[WIDTH];
        end
        MODO_DEC: begin
          diff = DW'(q_q) - DW'(1'b1);
          q_d  = diff[WIDTH-1:0];
          bo_d = (q_q == '0);
        end
        MODO_ACC: begin
          diff  = DW'(q_q) - DW'(B) - DW'(BI);
          q_d   = diff[WIDTH-1:0];
          bo_d  = diff[WIDTH];
          clamp = SAT & diff[WIDTH];
        end
        MODO_LOAD: begin
          q_d  = A;
          bo_d = 1'b0;
        end
        default: begin
          q_d  = q_q;
          bo_d = bo_q;
        end
      endcase
      // Saturating slices pin underflow at zero but still report the borrow
      if (clamp) q_d = '0;
      zero_d = (q_d == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      bo_q   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      bo_q   <= bo_d;
      zero_q <= zero_d;
    end
  end

  assign Q    = q_q;
  assign BO   = bo_q;
  assign ZERO = zero_q;

endmodule

// File: tb/tb_restador_8bits.sv
// Bench for restador_8bits: directed scenarios, a cascaded 16-bit pair and a SAT=1 slice,
// all checked against an integer-arithmetic reference model.
module tb_restador_8bits;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [1:0] modo;
  logic       bi;
  logic [7:0] a, b;
  logic [7:0] q0, q_sat, q1;
  logic       bo0, bo_sat, bo1;
  logic       zero0, zero_sat, zero1;
  logic       enb1;
  logic [1:0] modo1;
  logic [7:0] a1, b1;

  int vectors;
  int miscompares;
  bit started;

  // Model state: index 0 = wrapping slice, index 1 = saturating slice
  int mq[2];
  bit mbo[2];
  bit mz[2];

  restador_8bits #(.WIDTH(8), .SAT(1'b0)) u0 (
    .CLK(clk), .RST(rst), .ENB(enb), .MODO(modo), .BI(bi), .A(a), .B(b),
    .Q(q0), .BO(bo0), .ZERO(zero0)
  );

  restador_8bits #(.WIDTH(8), .SAT(1'b1)) u_sat (
    .CLK(clk), .RST(rst), .ENB(enb), .MODO(modo), .BI(bi), .A(a), .B(b),
    .Q(q_sat), .BO(bo_sat), .ZERO(zero_sat)
  );

  restador_8bits #(.WIDTH(8), .SAT(1'b0)) u1 (
    .CLK(clk), .RST(rst), .ENB(enb1), .MODO(modo1), .BI(bo0), .A(a1), .B(b1),
    .Q(q1), .BO(bo1), .ZERO(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (started && enb) begin
      assert (!$isunknown(modo)) else begin
        miscompares++;
        $error("FAIL modo_x: MODO=%b with ENB=1", modo);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer subtraction, borrow = result went negative
  task automatic model_update();
    int d;
    int nq;
    bit nb;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        mq[s] = 0; mbo[s] = 1'b0; mz[s] = 1'b1;
      end else if (enb) begin
        case (modo)
          2'b00:   d = int'(a) - int'(b) - int'(bi);
          2'b01:   d = mq[s] - 1;
          2'b10:   d = mq[s] - int'(b) - int'(bi);
          default: d = int'(a);
        endcase
        nb = (d < 0);
        if (s == 1 && modo != 2'b01 && nb) nq = 0;
        else nq = (d + 512) % 256;
        mq[s] = nq; mbo[s] = nb; mz[s] = (nq == 0);
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q"},      32'(q0),       32'(mq[0]));
    chk({tag, "_bo"},     32'(bo0),      32'(mbo[0]));
    chk({tag, "_zero"},   32'(zero0),    32'(mz[0]));
    chk({tag, "_satq"},   32'(q_sat),    32'(mq[1]));
    chk({tag, "_satbo"},  32'(bo_sat),   32'(mbo[1]));
    chk({tag, "_satz"},   32'(zero_sat), 32'(mz[1]));
  endtask

  initial begin
    int exp16;
    logic [15:0] x, y;
    vectors = 0; miscompares = 0; started = 1'b0;
    mq[0] = 0; mq[1] = 0; mbo[0] = 0; mbo[1] = 0; mz[0] = 1; mz[1] = 1;
    rst = 1'b1; enb = 1'b1; modo = 2'b11; bi = 1'b0; a = 8'hAA; b = 8'h00;
    enb1 = 1'b0; modo1 = 2'b00; a1 = 8'h00; b1 = 8'h00;

    // 1: reset overrides a pending load, then the load lands
    step(); step();
    chk("rst_q", 32'(q0), 32'h00);
    chk("rst_bo", 32'(bo0), 32'h0);
    chk("rst_zero", 32'(zero0), 32'h1);
    chk("rst_q1", 32'(q1), 32'h00);
    started = 1'b1;
    rst = 1'b0;
    step();
    chk("load_aa", 32'(q0), 32'hAA);
    chk("load_aa_zero", 32'(zero0), 32'h0);

    // 2: plain subtract, then underflow with borrow-in (wrap vs saturate)
    modo = 2'b00; a = 8'd50; b = 8'd20; bi = 1'b0;
    step();
    chk("sub_q", 32'(q0), 32'd30);
    chk("sub_bo", 32'(bo0), 32'h0);
    a = 8'd20; b = 8'd50; bi = 1'b1;
    step();
    chk("subu_q", 32'(q0), 32'hE1);
    chk("subu_bo", 32'(bo0), 32'h1);
    chk("subu_satq", 32'(q_sat), 32'h00);
    chk("subu_satbo", 32'(bo_sat), 32'h1);
    chk("subu_satz", 32'(zero_sat), 32'h1);
    bi = 1'b0;

    // 3: decrement through zero
    modo = 2'b11; a = 8'd2;
    step();
    modo = 2'b01;
    step();
    chk("dec1_q", 32'(q0), 32'd1);  chk("dec1_bo", 32'(bo0), 32'h0); chk("dec1_z", 32'(zero0), 32'h0);
    step();
    chk("dec0_q", 32'(q0), 32'd0);  chk("dec0_bo", 32'(bo0), 32'h0); chk("dec0_z", 32'(zero0), 32'h1);
    step();
    chk("decff_q", 32'(q0), 32'hFF); chk("decff_bo", 32'(bo0), 32'h1); chk("decff_z", 32'(zero0), 32'h0);
    chk("decff_satq", 32'(q_sat), 32'hFF);
    step();
    chk("decfe_q", 32'(q0), 32'hFE); chk("decfe_bo", 32'(bo0), 32'h0);

    // 4: running subtraction
    modo = 2'b11; a = 8'd100;
    step();
    modo = 2'b10; b = 8'd30; bi = 1'b0;
    step(); chk("acc70", 32'(q0), 32'd70);  chk("acc70_bo", 32'(bo0), 32'h0);
    step(); chk("acc40", 32'(q0), 32'd40);  chk("acc40_bo", 32'(bo0), 32'h0);
    step(); chk("acc10", 32'(q0), 32'd10);  chk("acc10_bo", 32'(bo0), 32'h0);
    step(); chk("acc236", 32'(q0), 32'd236); chk("acc236_bo", 32'(bo0), 32'h1);
    chk("acc_satq", 32'(q_sat), 32'd0);

    // 5: hold while disabled, then reset mid-count
    modo = 2'b11; a = 8'd6;
    step();
    modo = 2'b01;
    step();
    chk("pre_hold", 32'(q0), 32'h05);
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      modo = 2'(i); a = 8'(8'h30 + i); b = 8'(8'h90 + i); bi = ~bi;
      step();
    end
    chk("hold_q", 32'(q0), 32'h05);
    chk("hold_bo", 32'(bo0), 32'h0);
    chk("hold_z", 32'(zero0), 32'h0);
    enb = 1'b1; modo = 2'b01; bi = 1'b0; rst = 1'b1;
    step();
    chk("rstmid_q", 32'(q0), 32'h00);
    chk("rstmid_bo", 32'(bo0), 32'h0);
    rst = 1'b0;

    // Random single-slice traffic against the model (wrap and saturate)
    for (int i = 0; i < 300; i++) begin
      rst  = ($urandom_range(49) == 0);
      enb  = ($urandom_range(4) != 0);
      modo = 2'($urandom_range(3));
      a    = 8'($urandom);
      b    = 8'($urandom);
      bi   = 1'($urandom);
      step();
      chk_model("rnd");
    end
    rst = 1'b0;

    // 6: two cascaded slices; low BO feeds high BI
    enb = 1'b1; enb1 = 1'b1; modo = 2'b00; modo1 = 2'b00; bi = 1'b0;
    a1 = 8'h01; a = 8'h00; b1 = 8'h00; b = 8'h01;
    step(); step();
    chk("casc_q", 32'({q1, q0}), 32'h00FF);
    chk("casc_bo", 32'(bo1), 32'h0);
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if (i == 0) begin x = 16'h0000; y = 16'h0001; end
      {a1, a} = x; {b1, b} = y;
      step(); step();
      exp16 = int'(x) - int'(y);
      chk("casc_rnd_q", 32'({q1, q0}), 32'((exp16 + 65536) % 65536));
      chk("casc_rnd_bo", 32'(bo1), 32'(exp16 < 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
